// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment display peripheral.
// Holds the digit count, the all-dark segment pattern, the default bus
// address and the hex-to-segment lookup table (active-low {dp,g,f,e,d,c,b,a}).
package seg7_pkg;

   localparam int          NUM_DIGITS      = 8;
   localparam logic [7:0]  SEG_BLANK       = 8'hFF;
   localparam logic [11:0] SEGADDR_DEFAULT = 12'h000;

   // Entry k lives at bits [8*k +: 8]; decimal point is always off (bit 7 high).
   localparam logic [16*8-1:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
      8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
      8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
      8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
   };

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational hex nibble to active-low segment pattern,
// taken straight from the package lookup table.
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [7:0] seg
);

   assign seg = SEG_TABLE[{hex, 3'b000} +: 8];

endmodule

// File: rtl/seg7_display.sv
// seg7_display: write-only bus peripheral driving an 8-digit common-anode
// seven-segment display. A store to SEGADDR latches a 32-bit value that is
// shown as 8 hex digits, scanned one digit per SCAN_CYCLES clocks.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks digits above the
// most significant non-zero nibble (digit 0 is never blanked).
module seg7_display
   import seg7_pkg::*;
#(
   parameter logic [11:0] SEGADDR     = SEGADDR_DEFAULT,
   parameter int          SCAN_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_ena,
   input  logic [11:0] dv_addr,
   input  logic [31:0] data_fromcpu,
   output logic [7:0]  led_en,
   output logic [7:0]  led_seg
);

   localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);

   logic [31:0]      data_reg;
   logic [CNT_W-1:0] scan_cnt;
   logic [2:0]       idx;
   logic [3:0]       nibble_p0;
   logic [7:0]       dec_p0;
   logic [7:0]       seg_p0;
   logic             blank_p0;

   // Latch CPU stores addressed to this block; the last write in a burst wins.
   always_ff @(posedge clk) begin
      if (!rst_n)
         data_reg <= '0;
      else if (wr_ena && dv_addr == SEGADDR)
         data_reg <= data_fromcpu;
   end

   // Free-running scan timer; advances the digit index on terminal count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == CNT_LAST) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // ---- stage p0: select and decode the nibble for the current digit ----
   assign nibble_p0 = data_reg[{idx, 2'b00} +: 4];

   seg7_hex_decoder u_dec (
      .hex (nibble_p0),
      .seg (dec_p0)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [2:0] msd_p0;

   // Find the most significant non-zero nibble; all-zero data leaves digit 0.
   always_comb begin
      msd_p0 = 3'd0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (data_reg[4*i +: 4] != 4'h0)
            msd_p0 = 3'(i);
      end
   end

   assign blank_p0 = (idx > msd_p0);
`else
   assign blank_p0 = 1'b0;
`endif

   assign seg_p0 = blank_p0 ? SEG_BLANK : dec_p0;

   // ---- stage p1: registered digit enable and segment outputs ----
   // Register the active-low digit enable and segment pattern for the pre-edge digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_en  <= 8'hFF;
         led_seg <= SEG_BLANK;
      end else begin
         led_en  <= ~(8'b0000_0001 << idx);
         led_seg <= seg_p0;
      end
   end

endmodule

// File: tb/tb_seg7_display.sv
// tb_seg7_display: self-checking bench for seg7_display (SCAN_CYCLES = 4).
// A reference model tracks elapsed clocks since reset and the last accepted
// write; expected outputs follow from that with plain arithmetic. Table
// vectors pin the per-digit patterns to hand-written constants.
module tb_seg7_display;

   localparam int          SC   = 4;
   localparam logic [11:0] ADDR = 12'h000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_ena;
   logic [11:0] dv_addr;
   logic [31:0] data_fromcpu;
   logic [7:0]  led_en;
   logic [7:0]  led_seg;

   always #5 clk = ~clk;

   seg7_display #(
      .SEGADDR     (ADDR),
      .SCAN_CYCLES (SC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_ena       (wr_ena),
      .dv_addr      (dv_addr),
      .data_fromcpu (data_fromcpu),
      .led_en       (led_en),
      .led_seg      (led_seg)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          m_cyc;      // clocks since reset release (pre-edge)
   logic [31:0] m_data;     // last accepted write
   logic [7:0]  exp_en;
   logic [7:0]  exp_seg;
   int          shown_idx;  // digit shown after the latest edge

   typedef struct {
      logic [31:0] data;
      logic [63:0] segs;    // digit k expected at [8*k +: 8]
   } vec_t;

   vec_t tbl [5];

   function automatic logic [7:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
         4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
         4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
         4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
      endcase
   endfunction

   function automatic logic [7:0] ref_seg(input logic [31:0] d, input int digit);
      logic [31:0] upper;
      upper = d >> (4 * digit);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (digit != 0 && upper == 32'd0) return 8'hFF;
`endif
      return hex7(upper[3:0]);
   endfunction

   function automatic int next_idx();
      return (m_cyc / SC) % 8;
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, compare.
   task automatic step(input logic rn, input logic we, input logic [11:0] a, input logic [31:0] d);
      rst_n = rn; wr_ena = we; dv_addr = a; data_fromcpu = d;
      @(posedge clk);
      if (!rn) begin
         m_cyc = 0; m_data = 32'd0; exp_en = 8'hFF; exp_seg = 8'hFF; shown_idx = -1;
      end else begin
         shown_idx = (m_cyc / SC) % 8;
         exp_en    = ~(8'h01 << shown_idx);
         exp_seg   = ref_seg(m_data, shown_idx);
         m_cyc++;
         if (we && a == ADDR) m_data = d;
      end
      #1;
      check8("led_en", led_en, exp_en);
      check8("led_seg", led_seg, exp_seg);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, ADDR, 32'h0);
   endtask

   initial begin
      int guard;

      tbl[0] = '{32'h89AB_CDEF, {8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E}};
      tbl[1] = '{32'h1234_5678, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80}};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      tbl[2] = '{32'h0000_00A5, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'h92}};
      tbl[3] = '{32'h0000_0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
      tbl[4] = '{32'h00F0_0000, {8'hFF, 8'hFF, 8'h8E, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
`else
      tbl[2] = '{32'h0000_00A5, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h88, 8'h92}};
      tbl[3] = '{32'h0000_0000, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
      tbl[4] = '{32'h00F0_0000, {8'hC0, 8'hC0, 8'h8E, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
`endif

      rst_n = 1'b0; wr_ena = 1'b0; dv_addr = 12'h0; data_fromcpu = 32'h0;

      // Reset held 3 cycles (a write during reset is discarded), then free scan.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, ADDR, 32'hFFFF_FFFF);
      check8("reset_en", led_en, 8'hFF);
      check8("reset_seg", led_seg, 8'hFF);
      for (int i = 0; i < 36; i++) begin
         step(1'b1, 1'b0, ADDR, 32'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         check8("idle_seg", led_seg, (shown_idx == 0) ? 8'hC0 : 8'hFF);
`else
         check8("idle_seg", led_seg, 8'hC0);
`endif
      end

      // Table vectors: write, then watch a full scan of all 8 digits.
      for (int v = 0; v < 5; v++) begin
         step(1'b1, 1'b1, ADDR, tbl[v].data);
         for (int i = 0; i < 8 * SC; i++) begin
            step(1'b1, 1'b0, ADDR, 32'h0);
            check8("tbl_seg", led_seg, tbl[v].segs[8*shown_idx +: 8]);
         end
      end

      // Write to a foreign address and with wr_ena low: no effect.
      step(1'b1, 1'b1, ADDR, 32'h89AB_CDEF);
      step(1'b1, 1'b1, 12'h070, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, ADDR, 32'h0000_0000);
      idle(8 * SC);

      // Write on the same edge as the 7 -> 0 index wrap.
      guard = 0;
      while (!(next_idx() == 7 && (m_cyc % SC) == SC - 1) && guard < 64) begin
         step(1'b1, 1'b0, ADDR, 32'h0);
         guard++;
      end
      n_tests++;
      if (guard >= 64) begin
         n_fail++;
         $display("FAIL wrap_align: got %0d cycles, expected < 64", guard);
      end
      step(1'b1, 1'b1, ADDR, 32'h0000_0003);
      step(1'b1, 1'b0, ADDR, 32'h0);
      check8("wrap_en", led_en, 8'hFE);
      check8("wrap_seg", led_seg, 8'hB0);

      // Reset pulsed mid-scan at digit 5.
      step(1'b1, 1'b1, ADDR, 32'h1234_5678);
      guard = 0;
      while (!(next_idx() == 5 && (m_cyc % SC) == 1) && guard < 64) begin
         step(1'b1, 1'b0, ADDR, 32'h0);
         guard++;
      end
      check8("pre_rst_en", led_en, 8'hDF);
      step(1'b0, 1'b1, ADDR, 32'hDEAD_BEEF);
      check8("mid_rst_en", led_en, 8'hFF);
      check8("mid_rst_seg", led_seg, 8'hFF);
      step(1'b1, 1'b0, ADDR, 32'h0);
      check8("post_rst_en", led_en, 8'hFE);
      check8("post_rst_seg", led_seg, 8'hC0);

      // Randomized traffic against the model, including back-to-back writes and resets.
      for (int i = 0; i < 600; i++) begin
         logic        rn, we;
         logic [11:0] a;
         rn = ($urandom_range(0, 49) != 0);
         we = ($urandom_range(0, 2) == 0);
         a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : ADDR;
         if ($urandom_range(0, 3) == 0)
            step(rn, we, a, 32'($urandom) >> (4 * $urandom_range(0, 7)));
         else
            step(rn, we, a, 32'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
